// File: rtl/da_pkg.sv
// Shared types and defaults for the DAC output path.
package da_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef logic [DATA_W_DEFAULT-1:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/da_sample_fifo.sv
// Synchronous sample FIFO. The head is always presented combinationally.
// The occupancy count is kept separately from the wrapping pointers.
module da_sample_fifo
    import da_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign full    = (count_q == LVL_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign level   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Next pointer, count and storage contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset; an empty count makes stale words unreachable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and count registers; reset discards buffered samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/da_converter.sv
// Parallel DAC driver: buffers samples, divides sys_clk into DA_clk and
// updates the data bus on each DA_clk falling edge so it is stable for a
// half period before the DAC latches on the rising edge.
// Build option: DA_MIDSCALE_ON_UNDERFLOW_EN drives midscale on an empty pop
// instead of holding the last word.
module da_converter
    import da_pkg::*;
#(
    parameter int DA_CLK_MAX_CNT = 49,
    parameter int FIFO_DEPTH     = 16,
    parameter int DATA_W         = DATA_W_DEFAULT
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          DA_clk,
    output logic [DATA_W-1:0]             DA_digits_out,
    output logic                          sample_taken,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CNT_W = (DA_CLK_MAX_CNT > 0) ? $clog2(DA_CLK_MAX_CNT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DA_CLK_MAX_CNT);
`ifdef DA_MIDSCALE_ON_UNDERFLOW_EN
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              da_clk_q, da_clk_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              taken_q, taken_d;
    logic              underflow_q, underflow_d;

    logic              fifo_push, fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    // Readiness is purely occupancy based, so a full FIFO refuses a push
    // even in the cycle it pops.
    assign sample_ready = !fifo_full;
    assign fifo_push    = sample_valid && sample_ready;

    da_sample_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (sample_in),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Divider, run/idle control and falling-edge data update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        da_clk_d    = da_clk_q;
        dout_d      = dout_q;
        taken_d     = 1'b0;
        underflow_d = underflow_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                da_clk_d = 1'b0;
                if (enable) begin
                    state_d     = RUN;
                    underflow_d = 1'b0;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Forced low without consuming a sample.
                    state_d  = IDLE;
                    cnt_d    = '0;
                    da_clk_d = 1'b0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d    = '0;
                    da_clk_d = !da_clk_q;
                    if (da_clk_q) begin
                        if (!fifo_empty) begin
                            dout_d   = fifo_head;
                            fifo_pop = 1'b1;
                            taken_d  = 1'b1;
                        end else begin
                            underflow_d = 1'b1;
`ifdef DA_MIDSCALE_ON_UNDERFLOW_EN
                            dout_d = MIDSCALE;
`endif
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            da_clk_q    <= 1'b0;
            dout_q      <= '0;
            taken_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            da_clk_q    <= da_clk_d;
            dout_q      <= dout_d;
            taken_q     <= taken_d;
            underflow_q <= underflow_d;
        end
    end

    assign DA_clk        = da_clk_q;
    assign DA_digits_out = dout_q;
    assign sample_taken  = taken_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_da_converter.sv
// Bench for da_converter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_da_converter;
    import da_pkg::*;

    localparam int HALF  = 50;
    localparam int DEPTH = 16;
`ifdef DA_MIDSCALE_ON_UNDERFLOW_EN
    localparam logic [7:0] UF_DOUT = 8'h80;
`else
    localparam logic [7:0] UF_DOUT = 8'h00;
`endif

    logic       sys_clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       DA_clk;
    logic [7:0] DA_digits_out;
    logic       sample_taken;
    logic       underflow;
    logic [4:0] fifo_level;

    da_converter #(.DA_CLK_MAX_CNT(HALF-1), .FIFO_DEPTH(DEPTH), .DATA_W(8)) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .DA_clk        (DA_clk),
        .DA_digits_out (DA_digits_out),
        .sample_taken  (sample_taken),
        .underflow     (underflow),
        .fifo_level    (fifo_level)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    // Reference model: sample queue plus elapsed RUN cycles.
    sample_t    q[$];
    bit         m_run;
    int         m_t;
    logic       m_dclk, m_uf, m_taken;
    logic [7:0] m_dout;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_run = 1'b0; m_t = 0;
        m_dclk = 1'b0; m_uf = 1'b0; m_taken = 1'b0; m_dout = 8'h00;
    endtask

    task automatic model_step();
        bit do_push;
        do_push = sample_valid && (q.size() < DEPTH);
        m_taken = 1'b0;
        if (!m_run) begin
            m_dclk = 1'b0;
            if (enable) begin m_run = 1'b1; m_t = 0; m_uf = 1'b0; end
        end else if (!enable) begin
            m_run = 1'b0; m_dclk = 1'b0;
        end else begin
            m_t++;
            m_dclk = ((m_t / HALF) % 2) == 1;
            if (m_t % (2*HALF) == 0) begin
                if (q.size() > 0) begin
                    m_dout = q.pop_front(); m_taken = 1'b1;
                end else begin
                    m_uf = 1'b1; m_dout = (UF_DOUT != 8'h00) ? UF_DOUT : m_dout;
                end
            end
        end
        if (do_push) q.push_back(sample_in);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_taken(input string nm);
        int n = 0;
        do begin tick(); n++; end while (!sample_taken && n < 300);
        if (!sample_taken) chk({nm, " timeout"}, 0, 1);
    endtask

    task automatic wait_dclk_high(input string nm);
        int n = 0;
        do begin tick(); n++; end while (!DA_clk && n < 300);
        if (!DA_clk) chk({nm, " timeout"}, 0, 1);
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (chk_on) begin
                chk("DA_clk", int'(DA_clk), int'(m_dclk));
                chk("DA_digits_out", int'(DA_digits_out), int'(m_dout));
                chk("sample_taken", int'(sample_taken), int'(m_taken));
                chk("underflow", int'(underflow), int'(m_uf));
                chk("fifo_level", int'(fifo_level), q.size());
                chk("sample_ready", int'(sample_ready), int'(q.size() < DEPTH));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_in = 8'h00;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        chk_on = 1'b1;
        chk("rst ready", int'(sample_ready), 1);
        chk("rst level", int'(fifo_level), 0);
        chk("rst dclk", int'(DA_clk), 0);
        chk("rst dout", int'(DA_digits_out), 0);
        chk("rst uf", int'(underflow), 0);

        // Empty run: first rise after 50 edges, first fall (underflow) after 100.
        enable = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!DA_clk && n < 300);
        chk("first rise edge", n, 51);
        do begin tick(); n++; end while (!underflow && n < 300);
        chk("underflow edge", n, 101);
        chk("uf dclk low", int'(DA_clk), 0);
        chk("uf dout", int'(DA_digits_out), int'(UF_DOUT));

        // Three samples drained on successive falling toggles.
        enable = 1'b0;
        do_reset();
        sample_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin sample_in = 8'(8'h11 * i); tick(); end
        sample_valid = 1'b0;
        chk("pre-run level", int'(fifo_level), 3);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_taken("drain");
            chk("drain dout", int'(DA_digits_out), 8'h11 * (k + 1));
            chk("drain level", int'(fifo_level), 2 - k);
        end
        enable = 1'b0;
        tick();

        // Fill beyond depth while idle: 17th sample dropped.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            sample_valid = 1'b1; sample_in = 8'(i + 1);
            tick();
            if (i == 15) begin
                chk("full ready", int'(sample_ready), 0);
                chk("full level", int'(fifo_level), 16);
            end
        end
        sample_in = 8'hA5;
        tick();
        chk("overfill level", int'(fifo_level), 16);

        // Push held during the full-FIFO pop: refused that cycle, taken next.
        enable = 1'b1;
        wait_taken("full pop");
        chk("full pop dout", int'(DA_digits_out), 8'h01);
        chk("full pop level", int'(fifo_level), 15);
        chk("full pop ready", int'(sample_ready), 1);
        tick();
        chk("refill level", int'(fifo_level), 16);
        chk("refill ready", int'(sample_ready), 0);
        sample_valid = 1'b0; enable = 1'b0;
        tick();

        // Leave RUN on the edge that would have popped.
        do_reset();
        enable = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!underflow && n < 300);
        sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin sample_in = 8'(8'h41 + i); tick(); end
        sample_valid = 1'b0;
        wait_dclk_high("dclk high");
        repeat (HALF - 1) tick();
        chk("pre-stop dclk", int'(DA_clk), 1);
        enable = 1'b0;
        tick();
        chk("stop dclk", int'(DA_clk), 0);
        chk("stop taken", int'(sample_taken), 0);
        chk("stop level", int'(fifo_level), 4);
        chk("stop uf held", int'(underflow), 1);
        enable = 1'b1;
        tick();
        chk("reenable uf", int'(underflow), 0);

        // Asynchronous reset mid-RUN with 5 samples queued.
        sample_valid = 1'b1;
        sample_in = 8'h45; tick();
        sample_in = 8'h46; tick();
        sample_valid = 1'b0;
        wait_taken("pre-reset pop");
        chk("pre-reset dout", int'(DA_digits_out), 8'h41);
        chk("pre-reset level", int'(fifo_level), 5);
        wait_dclk_high("pre-reset dclk");
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async dclk", int'(DA_clk), 0);
        chk("async dout", int'(DA_digits_out), 0);
        chk("async level", int'(fifo_level), 0);
        chk("async uf", int'(underflow), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post-reset ready", int'(sample_ready), 1);
        enable = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/da_converter.md
Name: da_converter

Overview:
- Output-side counterpart of the ADC capture path: buffers 8-bit samples from the waveform/test-pattern logic and drives an external parallel DAC.
- Generates the DAC conversion clock (DA_clk) by dividing sys_clk.
- Presents a new data word on each DA_clk falling edge, so the data is stable for a half period before the DAC latches it on the rising edge.
- Sits between the on-chip sample source (valid/ready producer) and the DAC pins.

Parameters:
- DA_CLK_MAX_CNT, 49, half-period terminal count; DA_clk period = 2*(DA_CLK_MAX_CNT+1) sys_clk cycles (1 MHz at 100 MHz).
- FIFO_DEPTH, 16, sample buffer depth; must be a power of 2, at least 2.
- DATA_W, 8, sample width.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  1 = run DA_clk and consume samples; 0 = idle.
- sample_in  in  DATA_W  sample from the producer.
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  FIFO can accept a sample this cycle.
- DA_clk  out  1  DAC conversion clock.
- DA_digits_out  out  DATA_W  DAC data bus.
- sample_taken  out  1  one-cycle pulse when a sample is moved to DA_digits_out.
- underflow  out  1  sticky flag: a DA_clk falling edge found the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low.
- Reset values:
  - DA_clk=0, DA_digits_out=0, sample_taken=0, underflow=0, fifo_level=0.
  - Divider counter=0, FIFO empty.
  - sample_ready=1 once reset is released.
- Push:
  - sample_ready = (fifo_level != FIFO_DEPTH), combinational from the occupancy count.
  - A write occurs when sample_valid && sample_ready; the sample is visible at the FIFO head on the next cycle.
  - sample_valid while full is ignored, with no error flag.
- State machine (2 states):
  - IDLE: counter held at 0, DA_clk held at 0, DA_digits_out holds its last value. Pushes are still accepted. Go to RUN when enable=1.
  - RUN: counter increments each cycle. When the counter reaches DA_CLK_MAX_CNT, it clears to 0 and DA_clk toggles.
  - RUN to IDLE when enable=0. The transition is immediate: DA_clk forced to 0 and the counter cleared on the next edge.
  - A pending DA_clk falling transition caused by leaving RUN does NOT pop.
- Pop on falling toggle (DA_clk 1 to 0, in RUN only), in the same cycle as the toggle:
  - FIFO non-empty: DA_digits_out <= head, pop, sample_taken=1 for exactly that cycle.
  - FIFO empty: DA_digits_out unchanged (see Optional Feature), underflow <= 1, sample_taken=0.
- Rising toggle: no data change.
- Latency: first sample pushed while in RUN reaches DA_digits_out at the next falling toggle.
- Simultaneous push and pop:
  - Both take effect; fifo_level unchanged.
  - When the FIFO is full, sample_ready=0 still applies in that cycle (no write-through).
  - When the FIFO is empty, the pop sees empty, so underflow is set and the pushed word is stored.
- underflow is cleared only by reset or by the transition from IDLE to RUN.
- fifo_level wraps never: pointers are log2(FIFO_DEPTH) bits wide and wrap modulo depth; the count is tracked separately.
- Reset mid-operation: everything returns to reset values asynchronously and buffered samples are discarded.

Optional Feature:
- Macro: DA_MIDSCALE_ON_UNDERFLOW_EN.
- Defined: on an underflow pop, DA_digits_out <= 2^(DATA_W-1) (8'h80), i.e. DAC midscale/zero volts. The underflow flag is set as normal.
- Undefined: on underflow, DA_digits_out holds the last value.

Decomposition:
- Package da_pkg holds:
  - DATA_W default constant.
  - Sample typedef (logic [DATA_W-1:0]).
  - State enum {IDLE, RUN}.
- Sub-module da_sample_fifo: synchronous FIFO with push, pop, head, level, and full/empty outputs.
- da_converter holds the divider, the FSM and the output register.

Test Plan:
- Reset, then enable=1 with no pushes. Required: DA_clk period of 100 sys_clk cycles (high 50, low 50); underflow rises at the first falling toggle (cycle 100 after enable); DA_digits_out stays 0 (8'h80 with the macro).
- Push 8'h11, 8'h22, 8'h33 back-to-back, then enable. Required: DA_digits_out takes 11, 22, 33 on successive falling toggles, with one sample_taken pulse per toggle; fifo_level steps 3, 2, 1, 0.
- Push 17 samples with enable=0 and FIFO_DEPTH=16. Required: sample_ready=0 after the 16th; the 17th is dropped; fifo_level=16.
- Keep the FIFO full (level 16) and push on the exact cycle of a falling-toggle pop. Required: sample_ready=0 that cycle; the level goes to 15, then accepts the next cycle.
- Deassert enable while DA_clk=1 with 4 samples queued. Required: DA_clk=0 on the next cycle; no pop; fifo_level stays 4; re-enable clears underflow.
- Assert rst_n=0 asynchronously mid-RUN with 5 samples queued. Required: immediately DA_clk=0, DA_digits_out=0, fifo_level=0, underflow=0.
